// File: rtl/bip_pkg.sv
// Shared BIP datapath definitions: opcodes, sequencer state encoding and BAU op codes.
package bip_pkg;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_STO  = 3'b001;
    localparam logic [2:0] OP_LD   = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SUBI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    localparam logic BAU_ADD = 1'b1;
    localparam logic BAU_SUB = 1'b0;

    function automatic logic is_load(input logic [2:0] op);
        return (op == OP_LD) || (op == OP_LDI);
    endfunction

    function automatic logic is_add(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ADDI);
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/acc_sequencer_if.sv
// Decoder-to-sequencer command channel (valid/ready handshake).
interface acc_sequencer_if #(
    parameter int msb = 11
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
    logic [msb:0]   cmd_operand;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_operand,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_operand,
        output cmd_ready
    );
endinterface

// File: rtl/acc_flag_gen.sv
// Combinational zero/negative/signed-overflow flags for a BAU add/sub result.
module acc_flag_gen
    import bip_pkg::*;
#(
    parameter int msb = 11
) (
    input  logic [msb:0] a,
    input  logic [msb:0] b,
    input  logic         op,
    input  logic [msb:0] result,
    output logic         z,
    output logic         n,
    output logic         v
);
    logic res_sign_flip;

    always_comb begin
        res_sign_flip = (result[msb] != a[msb]);
        z = (result == '0);
        n = result[msb];
        // Add overflows only with like-signed operands, sub only with unlike-signed ones.
        if (op == BAU_ADD) begin
            v = (a[msb] == b[msb]) && res_sign_flip;
        end else begin
            v = (a[msb] != b[msb]) && res_sign_flip;
        end
    end
endmodule

// File: rtl/acc_sequencer.sv
// Accumulator sequencer driving the BAU add/sub unit; flags optional via ACC_FLAGS_EN.
//   state   | meaning
//   ST_IDLE | ready for a command; loads/stores complete in the accept cycle
//   ST_EXEC | BAU operands applied, ACC captures bau_result at end of cycle
//   ST_HALT | HLT executed; commands ignored until reset
module acc_sequencer
    import bip_pkg::*;
#(
    parameter int msb = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    acc_sequencer_if.slave       cmd,
    output logic [msb:0]         bau_a,
    output logic [msb:0]         bau_b,
    output logic                 bau_op,
    input  logic [msb:0]         bau_result,
    output logic [msb:0]         acc,
    output logic                 st_valid,
    output logic [msb:0]         st_data,
`ifdef ACC_FLAGS_EN
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_v,
`endif
    output logic                 halted
);
    seq_state_e   state_q, state_d;
    logic [msb:0] acc_q, acc_d;
    logic [msb:0] bau_b_q, bau_b_d;
    logic         bau_op_q, bau_op_d;
    logic         st_valid_q, st_valid_d;
    logic [msb:0] st_data_q, st_data_d;
    logic         halted_q, halted_d;
    logic         cmd_ready_q, cmd_ready_d;

`ifdef ACC_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_n_q, flag_n_d;
    logic flag_v_q, flag_v_d;
    logic gen_z, gen_n, gen_v;

    acc_flag_gen #(.msb(msb)) u_flag_gen (
        .a      (acc_q),
        .b      (bau_b_q),
        .op     (bau_op_q),
        .result (bau_result),
        .z      (gen_z),
        .n      (gen_n),
        .v      (gen_v)
    );
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        bau_b_d    = bau_b_q;
        bau_op_d   = bau_op_q;
        st_valid_d = 1'b0;
        st_data_d  = st_data_q;
        halted_d   = halted_q;
`ifdef ACC_FLAGS_EN
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;
        flag_v_d   = flag_v_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    if (is_load(cmd.cmd_op)) begin
                        acc_d = cmd.cmd_operand;
`ifdef ACC_FLAGS_EN
                        flag_z_d = (cmd.cmd_operand == '0);
                        flag_n_d = cmd.cmd_operand[msb];
                        flag_v_d = 1'b0;
`endif
                    end else if (cmd.cmd_op == OP_STO) begin
                        st_valid_d = 1'b1;
                        st_data_d  = acc_q;
                    end else if (is_add(cmd.cmd_op)) begin
                        bau_b_d  = cmd.cmd_operand;
                        bau_op_d = BAU_ADD;
                        state_d  = ST_EXEC;
                    end else if (is_sub(cmd.cmd_op)) begin
                        bau_b_d  = cmd.cmd_operand;
                        bau_op_d = BAU_SUB;
                        state_d  = ST_EXEC;
                    end else begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                end
            end
            ST_EXEC: begin
                acc_d   = bau_result;
`ifdef ACC_FLAGS_EN
                flag_z_d = gen_z;
                flag_n_d = gen_n;
                flag_v_d = gen_v;
`endif
                state_d = ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Ready is registered, so it is derived from where the FSM is heading.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            bau_b_q     <= '0;
            bau_op_q    <= 1'b0;
            st_valid_q  <= 1'b0;
            st_data_q   <= '0;
            halted_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef ACC_FLAGS_EN
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            bau_b_q     <= bau_b_d;
            bau_op_q    <= bau_op_d;
            st_valid_q  <= st_valid_d;
            st_data_q   <= st_data_d;
            halted_q    <= halted_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef ACC_FLAGS_EN
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_v_q    <= flag_v_d;
`endif
        end
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign bau_a         = acc_q;
    assign bau_b         = bau_b_q;
    assign bau_op        = bau_op_q;
    assign acc           = acc_q;
    assign st_valid      = st_valid_q;
    assign st_data       = st_data_q;
    assign halted        = halted_q;
`ifdef ACC_FLAGS_EN
    assign flag_z        = flag_z_q;
    assign flag_n        = flag_n_q;
    assign flag_v        = flag_v_q;
`endif
endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer with a behavioural BAU beside it; flags checked under ACC_FLAGS_EN.
module tb_acc_sequencer;
    import bip_pkg::*;

    localparam int MSB = 11;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [MSB:0]   bau_a, bau_b, bau_result, acc, st_data;
    logic           bau_op, st_valid, halted;
`ifdef ACC_FLAGS_EN
    logic           flag_z, flag_n, flag_v;
    logic           exp_z = 1'b0, exp_n = 1'b0, exp_v = 1'b0;
`endif

    int             errors = 0;
    int             checks = 0;
    int             cyc = 0;
    int             accept_cyc = 0;
    logic [MSB:0]   exp_acc = '0;
    logic [MSB:0]   st_q[$];

    acc_sequencer_if #(.msb(MSB)) cmd_if ();

    acc_sequencer #(.msb(MSB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_if.slave),
        .bau_a      (bau_a),
        .bau_b      (bau_b),
        .bau_op     (bau_op),
        .bau_result (bau_result),
        .acc        (acc),
        .st_valid   (st_valid),
        .st_data    (st_data),
`ifdef ACC_FLAGS_EN
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_v     (flag_v),
`endif
        .halted     (halted)
    );

    assign bau_result = bau_op ? (bau_a + bau_b) : (bau_a - bau_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Store monitor: every st_valid pulse must match the oldest expected store.
    always @(negedge clk) begin
        if (st_valid === 1'b1) begin
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL st_unexpected st_data=%h, no store expected", st_data);
            end else begin
                logic [MSB:0] e;
                e = st_q.pop_front();
                if (st_data !== e) begin
                    errors++;
                    $display("FAIL st_data got=%h expected=%h", st_data, e);
                end
            end
        end
    end

    function automatic void model_arith(input logic is_add_op, input logic [MSB:0] b);
        int sa, sb, r;
        sa = $signed(exp_acc);
        sb = $signed(b);
        r  = is_add_op ? sa + sb : sa - sb;
        exp_acc = is_add_op ? exp_acc + b : exp_acc - b;
`ifdef ACC_FLAGS_EN
        exp_v = (r > 2047) || (r < -2048);
        exp_z = (exp_acc == '0);
        exp_n = exp_acc[MSB];
`endif
    endfunction

    // Drive a command and wait (bounded) for its accept; returns #1 after the accept edge.
    task automatic send(input logic [2:0] op, input logic [MSB:0] opnd);
        bit done;
        done = 0;
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_op      = op;
        cmd_if.cmd_operand = opnd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (cmd_if.cmd_ready === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout op=%0d got no accept, expected accept within 20 cycles", op);
        end else begin
            accept_cyc = cyc;
            if (is_load(op)) begin
                exp_acc = opnd;
`ifdef ACC_FLAGS_EN
                exp_z = (opnd == '0);
                exp_n = opnd[MSB];
                exp_v = 1'b0;
`endif
            end else if (op == OP_STO) begin
                st_q.push_back(exp_acc);
            end else if (is_add(op) || is_sub(op)) begin
                model_arith(is_add(op), opnd);
            end
        end
    endtask

    task automatic idle();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic check_acc(input string tag);
        checks++;
        if (acc !== exp_acc) begin
            errors++;
            $display("FAIL %s acc got=%h expected=%h", tag, acc, exp_acc);
        end
`ifdef ACC_FLAGS_EN
        checks++;
        if ({flag_z, flag_n, flag_v} !== {exp_z, exp_n, exp_v}) begin
            errors++;
            $display("FAIL %s flags znv got=%b%b%b expected=%b%b%b", tag,
                     flag_z, flag_n, flag_v, exp_z, exp_n, exp_v);
        end
`endif
    endtask

    task automatic do_arith(input logic [2:0] op, input logic [MSB:0] opnd, input string tag);
        send(op, opnd);
        idle();
        checks++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_in_exec got=%b expected=0", tag, cmd_if.cmd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after_exec got=%b expected=1", tag, cmd_if.cmd_ready);
        end
        check_acc(tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_acc = '0;
`ifdef ACC_FLAGS_EN
        {exp_z, exp_n, exp_v} = 3'b000;
`endif
    endtask

    task automatic test_reset();
        cmd_if.cmd_op = OP_HLT;
        cmd_if.cmd_operand = '0;
        apply_reset();
        checks++;
        if ({cmd_if.cmd_ready, st_valid, halted, bau_op} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl ready/st_valid/halted/bau_op got=%b expected=1000",
                     {cmd_if.cmd_ready, st_valid, halted, bau_op});
        end
        checks++;
        if ({bau_b, st_data} !== '0) begin
            errors++;
            $display("FAIL reset_data bau_b=%h st_data=%h expected both 0", bau_b, st_data);
        end
        check_acc("reset");
    endtask

    task automatic test_ldi_sto();
        send(OP_LDI, 12'h123);
        check_acc("ldi_123");
        send(OP_STO, 12'h000);
        idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overflow();
        send(OP_LDI, 12'h7FF);
        do_arith(OP_ADDI, 12'h001, "addi_ovf");
        checks++;
        if (acc !== 12'h800) begin
            errors++;
            $display("FAIL addi_ovf_abs acc got=%h expected=800", acc);
        end
    endtask

    task automatic test_sub_wrap();
        send(OP_LDI, 12'h000);
        do_arith(OP_SUBI, 12'h001, "subi_wrap");
        do_arith(OP_ADDI, 12'h001, "addi_zero");
        send(OP_STO, 12'h000);
        idle();
    endtask

    task automatic test_back_to_back();
        int first_cyc;
        send(OP_LDI, 12'h000);
        send(OP_ADD, 12'h005);
        first_cyc = accept_cyc;
        send(OP_ADD, 12'h003);
        checks++;
        if (accept_cyc - first_cyc != 2) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d cycles expected=2", accept_cyc - first_cyc);
        end
        send(OP_STO, 12'h000);
        idle();
        checks++;
        if (acc !== 12'h008) begin
            errors++;
            $display("FAIL b2b_final acc got=%h expected=008", acc);
        end
        check_acc("b2b");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_exec();
        send(OP_LDI, 12'h020);
        send(OP_ADD, 12'h010);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_acc = '0;
`ifdef ACC_FLAGS_EN
        {exp_z, exp_n, exp_v} = 3'b000;
`endif
        checks++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec_ready got=%b expected=1", cmd_if.cmd_ready);
        end
        check_acc("rst_exec");
        @(posedge clk);
        #1;
        check_acc("rst_exec_hold");
    endtask

    task automatic test_halt();
        send(OP_LDI, 12'h0AA);
        send(OP_HLT, 12'h000);
        cmd_if.cmd_op = OP_LDI;
        cmd_if.cmd_operand = 12'h055;
        repeat (4) @(posedge clk);
        #1;
        idle();
        checks++;
        if ({halted, cmd_if.cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL halt_state halted/ready got=%b expected=10", {halted, cmd_if.cmd_ready});
        end
        check_acc("halt_ignore");
        apply_reset();
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_clear got=%b expected=0", halted);
        end
    endtask

    task automatic test_random();
        logic [MSB:0] v;
        int sel;
        for (int i = 0; i < 40; i++) begin
            v = MSB'($urandom);
            sel = $urandom_range(0, 4);
            case (sel)
                0: begin send(OP_LDI, v); check_acc("rnd_ldi"); end
                1: begin send(OP_LD, v); check_acc("rnd_ld"); end
                2: do_arith(OP_ADD, v, "rnd_add");
                3: do_arith(OP_SUBI, v, "rnd_sub");
                default: send(OP_STO, 12'h000);
            endcase
        end
        idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        test_reset();
        test_ldi_sto();
        test_overflow();
        test_sub_wrap();
        test_back_to_back();
        test_reset_in_exec();
        test_halt();
        test_random();
        checks++;
        if (st_q.size() != 0) begin
            errors++;
            $display("FAIL st_missing got=%0d outstanding stores expected=0", st_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Accumulator sequencer for the BIP datapath: accepts decoded instructions over a valid/ready command port and holds the accumulator (ACC). It drives operand/op pairs into the BAU add/sub unit and captures its result back into ACC. It also emits store data and halts on HLT. It is the initiator side of the BAU interface (supplies A, B, Op; consumes Result), placed between the instruction decoder and data memory.

## Interface
Parameters:
- msb, 11, MSB index of the datapath; data width is msb+1 bits (12 by default).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- cmd_valid  input  1  command present; cmd_op/cmd_operand must stay stable until accepted.
- cmd_ready  output  1  sequencer can accept; transfer when cmd_valid & cmd_ready at a rising edge.
- cmd_op  input  3  000 HLT, 001 STO, 010 LD, 011 LDI, 100 ADD, 101 ADDI, 110 SUB, 111 SUBI.
- cmd_operand  input  msb+1  memory data or sign-extended immediate (resolved upstream).
- bau_a  output  msb+1  to BAU A; equals ACC.
- bau_b  output  msb+1  to BAU B; registered operand.
- bau_op  output  1  to BAU Op; 1 = add, 0 = sub; registered.
- bau_result  input  msb+1  from BAU Result (combinational).
- acc  output  msb+1  current accumulator.
- st_valid  output  1  one-cycle store strobe.
- st_data  output  msb+1  store data, valid with st_valid.
- halted  output  1  HLT executed; sticky until reset.
- flag_z, flag_n, flag_v  output  1 each  zero/negative/overflow (only with ACC_FLAGS_EN).

## Operation
- States: IDLE, EXEC, HALT. 2-bit encoding from the package.
- IDLE: cmd_ready=1. On accept:
  - LD/LDI: ACC<=cmd_operand; stay IDLE.
  - STO: st_data<=ACC, st_valid<=1 for one cycle; stay IDLE.
  - ADD/ADDI: bau_b<=cmd_operand, bau_op<=1; go EXEC.
  - SUB/SUBI: bau_b<=cmd_operand, bau_op<=0; go EXEC.
  - HLT: halted<=1; go HALT.
- EXEC: cmd_ready=0. At end of cycle ACC<=bau_result; go IDLE.
- HALT: cmd_ready=0; all commands ignored; exit only via reset.
- Arithmetic is modulo 2^(msb+1) and wraps with no saturation. Operands are treated as two's complement for flags only.
- bau_b/bau_op hold their last value outside EXEC.
- cmd_valid while cmd_ready=0 has no effect; the command is taken once ready returns.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, ACC=0, bau_b=0, bau_op=0, st_valid=0, st_data=0, halted=0, flags=0. cmd_ready=1 from the first cycle after reset.
- LD/LDI latency: ACC updated at the accept edge. Back-to-back accepts are allowed every cycle.
- STO: st_valid high the cycle after the accept edge. The ACC value is the one before that edge.
- ADD/SUB: accept at edge k; EXEC during cycle k..k+1; ACC updated at edge k+1; cmd_ready high again after edge k+1. Throughput is one arithmetic op per 2 cycles.
- A STO accepted right after an ADD stores the updated ACC.
- Reset asserted during EXEC: result is discarded and reset values apply.
- Reset has priority over every command.

## Configuration
- ACC_FLAGS_EN defined: flag_z/flag_n/flag_v ports exist. They update together with ACC:
  - z = (ACC==0).
  - n = ACC[msb].
  - v = signed overflow of the add/sub (operand signs vs. result sign).
  - LD/LDI update z and n and clear v.
- ACC_FLAGS_EN undefined: flag ports and logic are absent. All other behaviour is identical.

## Structure
- bip_pkg: opcode constants (OP_HLT..OP_SUBI), state encodings (ST_IDLE, ST_EXEC, ST_HALT), BAU op constants (BAU_ADD=1, BAU_SUB=0).
- Sub-module acc_flag_gen (combinational flag computation from a, b, op, result) is instantiated only under ACC_FLAGS_EN.
- The BAU is instantiated beside acc_sequencer at datapath level, not inside it.

## Test plan
- Reset then LDI 0x123, STO: ACC=0x123 after the accept edge; st_valid one cycle with st_data=0x123.
- LDI 0x7FF, ADDI 0x001: cmd_ready low one cycle; ACC=0x800. With flags: v=1, n=1, z=0.
- LDI 0x000, SUBI 0x001: ACC=0xFFF (wrap), n=1, v=0. Then ADDI 0x001: ACC=0x000, z=1.
- Hold cmd_valid high with ADD 0x005 then ADD 0x003 from ACC=0: accepts 2 cycles apart; final ACC=0x008; no command lost or duplicated.
- Assert rst_n=0 during the EXEC of ADD 0x010 from ACC=0x020: ACC=0, state IDLE, cmd_ready=1 the next cycle.
- HLT, then LDI 0x055: halted=1, cmd_ready=0, ACC unchanged; after reset, halted=0.
